// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_mem_arbiter
// Purpose  : N-port shared data memory. Each core issues single-word
//            read/write requests over a req/ack handshake; a round-robin
//            arbiter serialises them onto one memory array, one access per
//            cycle, and counts contention cycles.
// Ports    : clk_i          - rising-edge clock
//            rst_i          - asynchronous active-high reset
//            req_i          - per-core request, held until ack
//            we_i           - per-core write enable (1 = write)
//            addr_i         - per-core byte address, slice k = [32k +: 32]
//            data_i         - per-core write data
//            lock_i         - per-core atomic-sequence hold
//            ack_o          - per-core one-cycle completion pulse
//            data_o         - per-core read data, held until next read ack
//            conflict_cnt_o - saturating count of cycles with >=2 eligible
// Config   : SMEM_LOCK_EN   - when defined, enables lock ownership; when
//                             undefined, lock_i is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module shared_mem_arbiter #(
    parameter int N_CORES = 2,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 128,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CORES-1:0]        req_i,
    input  logic [N_CORES-1:0]        we_i,
    input  logic [N_CORES*32-1:0]     addr_i,
    input  logic [N_CORES*DATA_W-1:0] data_i,
    input  logic [N_CORES-1:0]        lock_i,
    output logic [N_CORES-1:0]        ack_o,
    output logic [N_CORES*DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]          conflict_cnt_o
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = $clog2(N_CORES);

    logic [DATA_W-1:0]         r_mem [DEPTH];
    logic [N_CORES-1:0]        r_ack;
    logic [N_CORES*DATA_W-1:0] r_data;
    logic [CNT_W-1:0]          r_cnt;
    logic [c_PTR_W-1:0]        r_ptr;
`ifdef SMEM_LOCK_EN
    logic                      r_lock_vld;
    logic [c_PTR_W-1:0]        r_lock_own;
    logic                      w_lock;
`endif

    logic [N_CORES-1:0]        w_elig;
    logic                      w_gnt;
    logic [c_PTR_W-1:0]        w_win;
    logic [c_PTR_W-1:0]        w_ptr_nxt;
    logic [3:0]                w_n_elig;
    logic                      w_we;
    logic                      w_mem_we;
    logic [c_IDX_W-1:0]        w_idx;
    logic [DATA_W-1:0]         w_wdata;
    logic                      w_unused;

    // Position 'off' steps after 'base' in the circular core order.
    function automatic logic [c_PTR_W-1:0] f_rr_idx(input logic [c_PTR_W-1:0] base,
                                                     input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CORES) s = s - N_CORES;
        return c_PTR_W'(s);
    endfunction

    // A core is masked during its own ack cycle so a held req is not re-served.
    always_comb begin
        w_elig = req_i & ~r_ack;
`ifdef SMEM_LOCK_EN
        if (r_lock_vld) w_elig = w_elig & (N_CORES'(1) << r_lock_own);
`endif
    end

    // Round-robin pick starting at the pointer, plus eligible-requester count.
    always_comb begin
        w_gnt    = 1'b0;
        w_win    = '0;
        w_n_elig = '0;
        for (int i = 0; i < N_CORES; i++) begin
            w_n_elig = w_n_elig + 4'(w_elig[i]);
            if (!w_gnt && w_elig[f_rr_idx(r_ptr, i)]) begin
                w_gnt = 1'b1;
                w_win = f_rr_idx(r_ptr, i);
            end
        end
    end

    assign w_ptr_nxt = (w_win == c_PTR_W'(N_CORES - 1)) ? '0 : w_win + c_PTR_W'(1);
    assign w_we      = we_i[w_win];
    assign w_idx     = addr_i[32*int'(w_win) + 2 +: c_IDX_W];
    assign w_wdata   = data_i[DATA_W*int'(w_win) +: DATA_W];
    // Suppress the write while reset is asserted so a request caught by
    // reset never reaches the array.
    assign w_mem_we  = w_gnt & w_we & ~rst_i;
`ifdef SMEM_LOCK_EN
    assign w_lock    = lock_i[w_win];
`endif
    // Address bits outside the word index and (in the default build) lock_i
    // are intentionally ignored.
    assign w_unused  = ^{addr_i, lock_i};

    // Storage array: not reset, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) r_mem[w_idx] <= w_wdata;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack      <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
`ifdef SMEM_LOCK_EN
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
`endif
        end else begin
            r_ack <= '0;
            if (w_gnt) begin
                r_ack[w_win] <= 1'b1;
                if (!w_we) r_data[DATA_W*int'(w_win) +: DATA_W] <= r_mem[w_idx];
`ifdef SMEM_LOCK_EN
                // Only the owner can win while locked, so the winner's lock_i
                // alone decides whether ownership is taken, kept or released.
                r_lock_vld <= w_lock;
                r_lock_own <= w_win;
                if (!w_lock) r_ptr <= w_ptr_nxt;
`else
                r_ptr <= w_ptr_nxt;
`endif
            end
            if (w_n_elig >= 4'd2 && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ack_o          = r_ack;
    assign data_o         = r_data;
    assign conflict_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_mem_arbiter
// Purpose  : Self-checking bench for shared_mem_arbiter (4 cores, 128 words,
//            4-bit contention counter) with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_mem_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int CW    = 4;
`ifdef SMEM_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*32-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    lock;
    logic [N-1:0]    ack;
    logic [N*DW-1:0] rdata;
    logic [CW-1:0]   cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_ptr;
    int            m_owner;
    int            m_cnt;
    logic [N-1:0]  m_ack;
    logic [DW-1:0] m_mem  [DEPTH];
    logic [DW-1:0] m_data [N];
    logic [DW-1:0] fill_val [DEPTH];

    shared_mem_arbiter #(
        .N_CORES (N),
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .CNT_W   (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .data_i         (wdata),
        .lock_i         (lock),
        .ack_o          (ack),
        .data_o         (rdata),
        .conflict_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_eval();
        int nel;
        int win;
        int k;
        int idx;
        logic [N-1:0] el;
        logic [31:0]  a;
        if (rst) begin
            m_ptr   = 0;
            m_owner = -1;
            m_cnt   = 0;
            m_ack   = '0;
            for (int c = 0; c < N; c++) m_data[c] = '0;
            return;
        end
        nel = 0;
        for (int c = 0; c < N; c++) begin
            el[c] = req[c] && !m_ack[c];
            if (LOCK_ON && m_owner >= 0 && c != m_owner) el[c] = 1'b0;
            if (el[c]) nel++;
        end
        if (nel >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        win = -1;
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (win < 0 && el[k]) win = k;
        end
        m_ack = '0;
        if (win >= 0) begin
            m_ack[win] = 1'b1;
            a   = addr[win*32 +: 32];
            idx = int'((a >> 2) % DEPTH);
            if (we[win]) m_mem[idx] = wdata[win*DW +: DW];
            else         m_data[win] = m_mem[idx];
            if (LOCK_ON && lock[win]) begin
                m_owner = win;
            end else begin
                m_owner = -1;
                m_ptr   = (win + 1) % N;
            end
        end
    endtask

    function automatic logic [N*DW-1:0] exp_rdata();
        logic [N*DW-1:0] v;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = m_data[c];
        return v;
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input bit r, input bit w, input logic [31:0] a,
                            input logic [DW-1:0] d, input bit l);
        req[k]           = r;
        we[k]            = w;
        addr[k*32 +: 32] = a;
        wdata[k*DW +: DW] = d;
        lock[k]          = l;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
        n_checks++;
        if (rdata !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rdata); end
        n_checks++;
        if (cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            fill_val[i] = $urandom;
            set_core(0, 1'b1, 1'b1, 32'(i * 4), fill_val[i], 1'b0);
            tick();
            n_checks++;
            if (ack !== 4'b0001) begin
                n_fail++; $display("FAIL fill_ack[%0d]: got %b expected 0001", i, ack);
            end
            req[0] = 1'b0;
            tick();
        end
    endtask

    task automatic test_write_read();
        set_core(0, 1'b1, 1'b1, 32'h10, 32'h1234, 1'b0);
        tick();
        n_checks++;
        if (ack !== 4'b0001) begin n_fail++; $display("FAIL t1_wr_ack: got %b expected 0001", ack); end
        // Read request raised during the write's ack cycle: ignored this cycle.
        set_core(0, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFF, 1'b0);
        tick();
        n_checks++;
        if (ack !== 4'b0000) begin n_fail++; $display("FAIL t1_ackcycle_ignored: got %b expected 0000", ack); end
        tick();
        n_checks++;
        if (ack !== 4'b0001) begin n_fail++; $display("FAIL t1_rd_ack: got %b expected 0001", ack); end
        n_checks++;
        if (rdata[31:0] !== 32'h1234) begin n_fail++; $display("FAIL t1_rd_data: got %h expected 1234", rdata[31:0]); end
        req[0] = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        apply_reset();
        set_core(0, 1'b1, 1'b1, 32'h0, 32'd5, 1'b0);
        set_core(1, 1'b1, 1'b1, 32'h0, 32'd7, 1'b0);
        tick();
        n_checks++;
        if (ack !== 4'b0001) begin n_fail++; $display("FAIL t2_first_ack: got %b expected 0001", ack); end
        req[0] = 1'b0;
        tick();
        n_checks++;
        if (ack !== 4'b0010) begin n_fail++; $display("FAIL t2_second_ack: got %b expected 0010", ack); end
        req[1] = 1'b0;
        set_core(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        n_checks++;
        if (rdata[31:0] !== 32'd7) begin n_fail++; $display("FAIL t2_read: got %0d expected 7", rdata[31:0]); end
        n_checks++;
        if (cnt !== 4'd1) begin n_fail++; $display("FAIL t2_conflict_cnt: got %0d expected 1", cnt); end
        req[0] = 1'b0;
        tick();
        n_checks++;
        if (rdata[DW +: DW] !== 32'd0) begin n_fail++; $display("FAIL t2_write_keeps_data1: got %h expected 0", rdata[DW +: DW]); end
    endtask

    task automatic test_wrap();
        set_core(0, 1'b1, 1'b1, 32'h200, 32'd9, 1'b0);
        tick();
        req[0] = 1'b0;
        tick();
        set_core(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        n_checks++;
        if (rdata[31:0] !== 32'd9) begin n_fail++; $display("FAIL t4_wrap_read: got %0d expected 9", rdata[31:0]); end
        req[0] = 1'b0;
        set_core(2, 1'b1, 1'b0, 32'h203, 32'h0, 1'b0);
        tick();
        n_checks++;
        if (rdata[2*DW +: DW] !== 32'd9) begin n_fail++; $display("FAIL t4_lowbits_ignored: got %0d expected 9", rdata[2*DW +: DW]); end
        req[2] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ack;
        int exp_cnt;
        apply_reset();
        for (int k = 0; k < N; k++) set_core(k, 1'b1, 1'b0, $urandom, 32'h0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_ack = N'(1) << (c % N);
            exp_cnt = (c + 1 > 15) ? 15 : c + 1;
            n_checks++;
            if (ack !== exp_ack) begin n_fail++; $display("FAIL t3_rr_order[%0d]: got %b expected %b", c, ack, exp_ack); end
            n_checks++;
            if (cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL t3_cnt_sat[%0d]: got %0d expected %0d", c, cnt, exp_cnt); end
        end
        n_checks++;
        if (rdata !== exp_rdata()) begin n_fail++; $display("FAIL t3_rr_data: got %h expected %h", rdata, exp_rdata()); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_request();
        set_core(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (cnt !== '0 || rdata !== '0) begin
            n_fail++; $display("FAIL t5_async_clear: got cnt=%0d data=%h expected 0", cnt, rdata);
        end
        tick();
        rst = 1'b0;
        req = '0;
        n_checks++;
        if (ack !== '0) begin n_fail++; $display("FAIL t5_no_ack: got %b expected 0", ack); end
        tick();
        n_checks++;
        if (ack !== '0) begin n_fail++; $display("FAIL t5_no_late_ack: got %b expected 0", ack); end
        set_core(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        tick();
        n_checks++;
        if (rdata[31:0] !== fill_val[16]) begin
            n_fail++; $display("FAIL t5_word_kept: got %h expected %h", rdata[31:0], fill_val[16]);
        end
        req[0] = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        logic [N-1:0] exp_ack;
        apply_reset();
        set_core(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        tick();
        n_checks++;
        if (ack !== 4'b0010) begin n_fail++; $display("FAIL t6_lock_rd_ack: got %b expected 0010", ack); end
        set_core(1, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0);
        set_core(0, 1'b1, 1'b1, 32'h24, 32'h66, 1'b0);
        tick();
        exp_ack = LOCK_ON ? 4'b0000 : 4'b0001;
        n_checks++;
        if (ack !== exp_ack) begin n_fail++; $display("FAIL t6_step2: got %b expected %b", ack, exp_ack); end
        if (m_ack[0]) req[0] = 1'b0;
        tick();
        n_checks++;
        if (ack !== 4'b0010) begin n_fail++; $display("FAIL t6_unlock_wr_ack: got %b expected 0010", ack); end
        req[1] = 1'b0;
        tick();
        exp_ack = LOCK_ON ? 4'b0001 : 4'b0000;
        n_checks++;
        if (ack !== exp_ack) begin n_fail++; $display("FAIL t6_step4: got %b expected %b", ack, exp_ack); end
        n_checks++;
        if (cnt !== '0) begin n_fail++; $display("FAIL t6_cnt: got %0d expected 0", cnt); end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] pending;
        apply_reset();
        pending = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (pending[k] && m_ack[k]) pending[k] = 1'b0;
                if (!pending[k]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        pending[k] = 1'b1;
                        set_core(k, 1'b1, 1'($urandom), $urandom, $urandom,
                                 ($urandom_range(0, 3) == 0));
                    end else begin
                        set_core(k, 1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom));
                    end
                end
            end
            tick();
            n_checks++;
            if (ack !== m_ack) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b expected %b", c, ack, m_ack); end
            n_checks++;
            if (rdata !== exp_rdata()) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, rdata, exp_rdata()); end
            n_checks++;
            if (cnt !== CW'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", c, cnt, m_cnt); end
        end
        req = '0;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        lock  = '0;
        m_ptr = 0; m_owner = -1; m_cnt = 0; m_ack = '0;
        test_reset();
        test_fill();
        test_write_read();
        test_contention();
        test_wrap();
        test_round_robin();
        test_reset_mid_request();
        test_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
